// File: rtl/mac_act_wb.sv
`default_nettype none
// ============================================================================
// Module      : mac_act_wb
// Description : MAC write-back stage. Adds the bias to each accumulated dot
//               product, rounds and rescales it to the output format,
//               saturates it, applies the activation and writes one result
//               per neuron into the output RAM. A one-deep buffer holds a MAC
//               result that arrives while a previous one is in flight.
//               Optional macro: ACT_RELU_EN (ReLU activation; identity when
//               undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_act_wb #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int AW      = 8,
    parameter int NEURONS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mac_done,
    input  logic [ACC_W-1:0]    mac_acc,
    output logic [AW-1:0]       bias_addr,
    input  logic [OUT_W-1:0]    bias_data,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [OUT_W-1:0]    wr_data,
    output logic                busy,
    output logic                layer_done,
    output logic                sat,
    output logic                ovr
);

    // Datapath width: one guard bit for the bias add plus one for the
    // rounding constant, so no intermediate step can wrap.
    localparam int c_DW = ACC_W + 2;

    localparam logic [AW-1:0]          c_LAST = AW'(NEURONS - 1);
    localparam logic signed [c_DW-1:0] c_RND  = {{(c_DW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [c_DW-1:0] c_MAX  = {{(c_DW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_DW-1:0] c_MIN  = {{(c_DW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_BIAS  = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_cnt;
    logic [ACC_W-1:0]        r_acc;
    logic [OUT_W-1:0]        r_bias;
    logic                    r_pend_vld;
    logic [ACC_W-1:0]        r_pend_acc;

    logic signed [c_DW-1:0]  w_acc_ext;
    logic signed [c_DW-1:0]  w_bias_sh;
    logic signed [c_DW-1:0]  w_sum;
    logic signed [c_DW-1:0]  w_shr;
    logic [OUT_W-1:0]        w_sat_val;
    logic                    w_clamp;
    logic [OUT_W-1:0]        w_result;
    logic                    w_last;
    logic                    w_pend_store;
    logic                    w_pend_drop;

    // Bias add, round-half-up rescale, saturation and activation
    always_comb begin
        w_acc_ext = {{(c_DW-ACC_W){r_acc[ACC_W-1]}}, r_acc};
        w_bias_sh = {{(c_DW-OUT_W){r_bias[OUT_W-1]}}, r_bias} <<< SHIFT;
        w_sum     = w_acc_ext + w_bias_sh + c_RND;
        w_shr     = w_sum >>> SHIFT;
        w_clamp   = 1'b0;
        if (w_shr > c_MAX) begin
            w_sat_val = c_MAX[OUT_W-1:0];
            w_clamp   = 1'b1;
        end else if (w_shr < c_MIN) begin
            w_sat_val = c_MIN[OUT_W-1:0];
            w_clamp   = 1'b1;
        end else begin
            w_sat_val = w_shr[OUT_W-1:0];
        end
`ifdef ACT_RELU_EN
        w_result = w_sat_val[OUT_W-1] ? '0 : w_sat_val;
`else
        w_result = w_sat_val;
`endif
    end

    // Pending-buffer decisions for a mac_done arriving outside WAIT
    always_comb begin
        w_last       = (r_cnt == c_LAST);
        w_pend_store = mac_done & ~r_pend_vld;
        w_pend_drop  = mac_done &  r_pend_vld;
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_bias     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_acc <= '0;
            bias_addr  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            sat        <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            layer_done <= 1'b0;
            if (start) begin
                // start overrides everything, including a same-cycle mac_done
                r_state    <= S_WAIT;
                r_cnt      <= '0;
                r_pend_vld <= 1'b0;
                bias_addr  <= '0;
                busy       <= 1'b1;
                sat        <= 1'b0;
                ovr        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // mac_done outside a layer is ignored
                    end
                    S_WAIT: begin
                        // bias_addr already equals r_cnt, so bias_data is
                        // valid during the following BIAS cycle
                        if (r_pend_vld) begin
                            r_acc   <= r_pend_acc;
                            r_state <= S_BIAS;
                            if (mac_done) begin
                                r_pend_acc <= mac_acc;
                            end else begin
                                r_pend_vld <= 1'b0;
                            end
                        end else if (mac_done) begin
                            r_acc   <= mac_acc;
                            r_state <= S_BIAS;
                        end
                    end
                    S_BIAS: begin
                        r_bias  <= bias_data;
                        r_state <= S_CALC;
                        if (w_pend_store) begin
                            r_pend_vld <= 1'b1;
                            r_pend_acc <= mac_acc;
                        end
                        if (w_pend_drop) begin
                            ovr <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        wr_en   <= 1'b1;
                        wr_addr <= r_cnt;
                        wr_data <= w_result;
                        sat     <= sat | w_clamp;
                        // Pre-address the next bias so a pending result can
                        // go straight from WRITE to BIAS
                        bias_addr <= w_last ? '0 : r_cnt + AW'(1);
                        r_state   <= S_WRITE;
                        if (w_pend_store) begin
                            r_pend_vld <= 1'b1;
                            r_pend_acc <= mac_acc;
                        end
                        if (w_pend_drop) begin
                            ovr <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (w_last) begin
                            layer_done <= 1'b1;
                            busy       <= 1'b0;
                            r_pend_vld <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                            if (r_pend_vld) begin
                                r_acc   <= r_pend_acc;
                                r_state <= S_BIAS;
                                if (mac_done) begin
                                    r_pend_acc <= mac_acc;
                                end else begin
                                    r_pend_vld <= 1'b0;
                                end
                            end else begin
                                r_state <= S_WAIT;
                                if (mac_done) begin
                                    r_pend_vld <= 1'b1;
                                    r_pend_acc <= mac_acc;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_act_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_act_wb
// Description : Self-checking bench for mac_act_wb (NEURONS=4). Table of
//               single-neuron vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_act_wb;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mac_done;
    logic [31:0] mac_acc;
    logic [7:0]  bias_addr;
    logic [15:0] bias_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        layer_done;
    logic        sat;
    logic        ovr;

    logic [15:0] bias_mem [0:255];

    int n_checks;
    int n_errors;

    mac_act_wb #(
        .ACC_W(32), .OUT_W(16), .SHIFT(8), .AW(8), .NEURONS(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mac_done   (mac_done),
        .mac_acc    (mac_acc),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .layer_done (layer_done),
        .sat        (sat),
        .ovr        (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bias RAM model: data valid one cycle after the address
    always @(posedge clk) bias_data <= bias_mem[bias_addr];

    typedef struct {
        logic [31:0] acc;
        logic [15:0] bias;
        logic [15:0] exp_id;
        logic [15:0] exp_relu;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pulse mac_done for one cycle; returns in cycle T+1
    task automatic pulse(input logic [31:0] acc);
        mac_acc  = acc;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_d;
        int          nw;
        logic [7:0]  wa [4];
        logic [15:0] wd [4];

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mac_done = 1'b0;
        mac_acc  = '0;
        bias_data = '0;
        for (int i = 0; i < 256; i++) bias_mem[i] = 16'h0000;

        //            acc            bias      identity  relu      sat
        vecs[0] = '{32'h0000_0300, 16'h0002, 16'h0005, 16'h0005, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[2] = '{32'h0000_0180, 16'h0000, 16'h0002, 16'h0002, 1'b0};
        vecs[3] = '{32'h0000_017F, 16'h0000, 16'h0001, 16'h0001, 1'b0};
        vecs[4] = '{32'hFFFF_FB00, 16'h0000, 16'hFFFB, 16'h0000, 1'b0};
        vecs[5] = '{32'h8000_0000, 16'h0000, 16'h8000, 16'h0000, 1'b1};
        vecs[6] = '{32'h0000_0000, 16'hFFFE, 16'hFFFE, 16'h0000, 1'b0};
        vecs[7] = '{32'h7FFF_0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[8] = '{32'hFFFF_FF80, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[9] = '{32'hFFFF_FF7F, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};

        // Reset state
        tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_sat", sat, 0);
        check("rst_ovr", ovr, 0);
        check("rst_addrs", {bias_addr, wr_addr}, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        tick();

        // mac_done while idle is ignored
        pulse(32'h0000_0100);
        for (int c = 0; c < 6; c++) begin
            if (wr_en) check("idle_no_write", wr_en, 0);
            tick();
        end
        check("idle_busy", busy, 0);
        check("idle_ovr", ovr, 0);

        // start and mac_done together: start wins
        start    = 1'b1;
        mac_done = 1'b1;
        mac_acc  = 32'h0000_0100;
        tick();
        start    = 1'b0;
        mac_done = 1'b0;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            if (wr_en) nw++;
            tick();
        end
        check("start_wins_no_write", nw, 0);
        check("start_wins_busy", busy, 1);

        // Table-driven single-neuron vectors
        foreach (vecs[i]) begin
`ifdef ACT_RELU_EN
            exp_d = vecs[i].exp_relu;
`else
            exp_d = vecs[i].exp_id;
`endif
            bias_mem[0] = vecs[i].bias;
            do_start();
            pulse(vecs[i].acc);                 // now T+1
            tick();                             // T+2
            check($sformatf("v%0d_early_wr_en", i), wr_en, 0);
            tick();                             // T+3
            check($sformatf("v%0d_wr_en", i), wr_en, 1);
            check($sformatf("v%0d_wr_addr", i), wr_addr, 0);
            check($sformatf("v%0d_wr_data", i), wr_data, exp_d);
            check($sformatf("v%0d_sat", i), sat, vecs[i].exp_sat);
            tick();                             // T+4
            check($sformatf("v%0d_wr_en_once", i), wr_en, 0);
            check($sformatf("v%0d_wr_data_hold", i), wr_data, exp_d);
        end

        // Full layer: mac_done every 4 cycles, value i + bias i -> 2i
        for (int i = 0; i < 4; i++) bias_mem[i] = 16'(i);
        do_start();
        for (int i = 0; i < 4; i++) begin
            pulse(32'(i) << 8);
            tick();
            tick();
            check($sformatf("layer_wr_en%0d", i), wr_en, 1);
            check($sformatf("layer_wr_addr%0d", i), wr_addr, i);
            check($sformatf("layer_wr_data%0d", i), wr_data, 2 * i);
            if (i < 3) check($sformatf("layer_done_early%0d", i), layer_done, 0);
            tick();
        end
        check("layer_done_pulse", layer_done, 1);
        tick();
        check("layer_done_single", layer_done, 0);
        check("layer_busy_low", busy, 0);

        // Three back-to-back mac_done: two written, third dropped
        for (int i = 0; i < 4; i++) bias_mem[i] = 16'h0000;
        do_start();
        mac_done = 1'b1;
        mac_acc  = 32'h0000_0100;
        tick();
        mac_acc  = 32'h0000_0200;
        tick();
        mac_acc  = 32'h0000_0300;
        tick();
        mac_done = 1'b0;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            if (wr_en) begin
                if (nw < 4) begin
                    wa[nw] = wr_addr;
                    wd[nw] = wr_data;
                end
                nw++;
            end
            tick();
        end
        check("burst_write_count", nw, 2);
        if (nw >= 2) begin
            check("burst_addr0", wa[0], 0);
            check("burst_data0", wd[0], 16'h0001);
            check("burst_addr1", wa[1], 1);
            check("burst_data1", wd[1], 16'h0002);
        end
        check("burst_ovr", ovr, 1);

        // Reset during CALC aborts the layer
        do_start();
        pulse(32'h0000_0500);                   // T+1 BIAS
        tick();                                 // T+2 CALC
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {wr_en, busy, layer_done, sat, ovr}, 0);
        check("abort_data", {bias_addr, wr_addr, wr_data}, 0);
        tick();
        rst_n = 1'b1;
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            if (wr_en) nw++;
            tick();
        end
        check("abort_no_write", nw, 0);
        bias_mem[0] = 16'h0001;
        do_start();
        pulse(32'h0000_0200);
        tick();
        tick();
        check("after_abort_wr_en", wr_en, 1);
        check("after_abort_data", wr_data, 16'h0003);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
